// File: rtl/mm_rd_arb_pkg.sv
// mm_rd_arb_pkg: shared types for the matrix-multiply read-port arbiter.
//   arb_state_e : arbitration / drain FSM encoding
//   RQ_VEC1/2   : requester IDs carried in the top mdata bit
package mm_rd_arb_pkg;

  typedef enum logic [1:0] {
    ST_ARB     = 2'd0,
    ST_DRAIN   = 2'd1,
    ST_DRAINED = 2'd2
  } arb_state_e;

  localparam logic RQ_VEC1 = 1'b0;
  localparam logic RQ_VEC2 = 1'b1;

endpackage

// File: rtl/mm_rd_credit.sv
// mm_rd_credit: per-requester outstanding-read counter.
//   clk, rst  : clock, synchronous active-high reset
//   inc       : a read was granted this cycle
//   dec       : a response for this requester arrived this cycle
//   count     : reads in flight (saturates at 0 and MAX_OUTSTANDING)
//   full      : count == MAX_OUTSTANDING, requester must be masked
//   empty     : count == 0
//   underflow : response arrived while nothing was outstanding
module mm_rd_credit #(
  parameter int MAX_OUTSTANDING = 32,
  localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          underflow
);

  assign full      = (count == CW'(MAX_OUTSTANDING));
  assign empty     = (count == '0);
  assign underflow = dec & empty;

  // Simultaneous inc/dec cancel; otherwise move one step, never wrapping.
  always_ff @(posedge clk) begin
    if (rst)
      count <= '0;
    else if (inc && !dec && !full)
      count <= count + CW'(1);
    else if (dec && !inc && !empty)
      count <= count - CW'(1);
  end

endmodule

// File: rtl/mm_rd_arbiter.sv
// mm_rd_arbiter: shares one CCI read channel between the vec1 (ID 0) and
// vec2 (ID 1) fetch streams. Round-robin grant, per-requester credit limit,
// responses routed back by mdata[MDATA-1], drain handshake for phase changes.
//   rqK_valid/addr/tag/ready : requester K request handshake (ready is comb)
//   rd_req_*                 : registered CCI read request
//   rd_rsp_*                 : CCI read response
//   rspK_valid, rsp_tag/data : registered routed response (tag/data shared)
//   drain / drained          : stop grants / all reads returned
//   rsp_err                  : sticky, response with nothing outstanding
// Optional: define MM_RD_ARB_STATS_EN to add grant_cnt0/1 and stall_cnt.
module mm_rd_arbiter
  import mm_rd_arb_pkg::*;
#(
  parameter int ADDR_LMT        = 20,
  parameter int MDATA           = 14,
  parameter int CACHE_WIDTH     = 512,
  parameter int MAX_OUTSTANDING = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rq0_valid,
  input  logic                   rq1_valid,
  input  logic [ADDR_LMT-1:0]    rq0_addr,
  input  logic [ADDR_LMT-1:0]    rq1_addr,
  input  logic [MDATA-2:0]       rq0_tag,
  input  logic [MDATA-2:0]       rq1_tag,
  output logic                   rq0_ready,
  output logic                   rq1_ready,
  output logic [ADDR_LMT-1:0]    rd_req_addr,
  output logic [MDATA-1:0]       rd_req_mdata,
  output logic                   rd_req_en,
  input  logic                   rd_req_almostfull,
  input  logic                   rd_rsp_valid,
  input  logic [MDATA-1:0]       rd_rsp_mdata,
  input  logic [CACHE_WIDTH-1:0] rd_rsp_data,
  output logic                   rsp0_valid,
  output logic                   rsp1_valid,
  output logic [MDATA-2:0]       rsp_tag,
  output logic [CACHE_WIDTH-1:0] rsp_data,
  input  logic                   drain,
  output logic                   drained,
`ifdef MM_RD_ARB_STATS_EN
  output logic [31:0]            grant_cnt0,
  output logic [31:0]            grant_cnt1,
  output logic [31:0]            stall_cnt,
`endif
  output logic                   rsp_err
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);

  arb_state_e           state, state_nxt;
  logic                 arb_open;
  logic                 last;
  logic                 elig0, elig1, grant, rsp_id;
  logic [1:0]           inc, dec, full, empty, underflow;
  logic [1:0][CW-1:0]   cnt;
  logic                 unused_cnt;

  // ---------------- credit counters ----------------
  assign rsp_id = rd_rsp_mdata[MDATA-1];
  assign inc    = {rq1_ready, rq0_ready};
  assign dec    = {rd_rsp_valid & rsp_id, rd_rsp_valid & ~rsp_id};

  for (genvar k = 0; k < 2; k++) begin : g_cred
    mm_rd_credit #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_credit (
      .clk       (clk),
      .rst       (rst),
      .inc       (inc[k]),
      .dec       (dec[k]),
      .count     (cnt[k]),
      .full      (full[k]),
      .empty     (empty[k]),
      .underflow (underflow[k])
    );
  end

  // Counts are kept as a debug tap; control uses the full/empty flags.
  assign unused_cnt = ^cnt;

  // ---------------- arbitration ----------------
  // drain is also gated directly so no grant slips out in the cycle it rises.
  always_comb begin
    elig0     = arb_open & ~drain & ~rd_req_almostfull & rq0_valid & ~full[0];
    elig1     = arb_open & ~drain & ~rd_req_almostfull & rq1_valid & ~full[1];
    // On a tie the requester that did not win last time goes.
    rq0_ready = elig0 & (~elig1 | last);
    rq1_ready = elig1 & (~elig0 | ~last);
    grant     = rq0_ready | rq1_ready;
  end

  // ---------------- drain FSM ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= ST_ARB;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_ARB:     if (drain) state_nxt = ST_DRAIN;
      ST_DRAIN:   if (!drain)       state_nxt = ST_ARB;
                  else if (&empty)  state_nxt = ST_DRAINED;
      ST_DRAINED: if (!drain) state_nxt = ST_ARB;
      default:    state_nxt = ST_ARB;
    endcase
  end

  always_comb begin
    arb_open = (state == ST_ARB);
    drained  = (state == ST_DRAINED);
  end

  // ---------------- request / response datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last         <= RQ_VEC2;
      rd_req_en    <= 1'b0;
      rd_req_addr  <= '0;
      rd_req_mdata <= '0;
      rsp0_valid   <= 1'b0;
      rsp1_valid   <= 1'b0;
      rsp_tag      <= '0;
      rsp_data     <= '0;
      rsp_err      <= 1'b0;
    end else begin
      rd_req_en <= grant;
      if (grant) begin
        last         <= rq1_ready;
        rd_req_addr  <= rq1_ready ? rq1_addr : rq0_addr;
        rd_req_mdata <= rq1_ready ? {RQ_VEC2, rq1_tag} : {RQ_VEC1, rq0_tag};
      end
      rsp0_valid <= dec[0];
      rsp1_valid <= dec[1];
      if (rd_rsp_valid) begin
        rsp_tag  <= rd_rsp_mdata[MDATA-2:0];
        rsp_data <= rd_rsp_data;
      end
      if (|underflow) rsp_err <= 1'b1;
    end
  end

`ifdef MM_RD_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt0 <= '0;
      grant_cnt1 <= '0;
      stall_cnt  <= '0;
    end else begin
      if (rq0_ready) grant_cnt0 <= grant_cnt0 + 32'd1;
      if (rq1_ready) grant_cnt1 <= grant_cnt1 + 32'd1;
      if ((rq0_valid | rq1_valid) & ~grant) stall_cnt <= stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_rd_arbiter.sv
// tb_mm_rd_arbiter: directed stimulus with a cycle-level reference model
// (outstanding counts as plain ints, drain phase as an int) checked every
// cycle, plus literal expectations for the listed scenarios.
module tb_mm_rd_arbiter;
  localparam int AL = 20, MD = 14, CWD = 512, MO = 4;

  logic           clk, rst;
  logic           rq0_valid, rq1_valid, rq0_ready, rq1_ready;
  logic [AL-1:0]  rq0_addr, rq1_addr, rd_req_addr;
  logic [MD-2:0]  rq0_tag, rq1_tag, rsp_tag;
  logic [MD-1:0]  rd_req_mdata, rd_rsp_mdata;
  logic           rd_req_en, rd_req_almostfull, rd_rsp_valid;
  logic [CWD-1:0] rd_rsp_data, rsp_data;
  logic           rsp0_valid, rsp1_valid, drain, drained, rsp_err;
`ifdef MM_RD_ARB_STATS_EN
  logic [31:0]    grant_cnt0, grant_cnt1, stall_cnt;
`endif

  mm_rd_arbiter #(.ADDR_LMT(AL), .MDATA(MD), .CACHE_WIDTH(CWD),
                  .MAX_OUTSTANDING(MO)) dut (
    .clk(clk), .rst(rst),
    .rq0_valid(rq0_valid), .rq1_valid(rq1_valid),
    .rq0_addr(rq0_addr), .rq1_addr(rq1_addr),
    .rq0_tag(rq0_tag), .rq1_tag(rq1_tag),
    .rq0_ready(rq0_ready), .rq1_ready(rq1_ready),
    .rd_req_addr(rd_req_addr), .rd_req_mdata(rd_req_mdata),
    .rd_req_en(rd_req_en), .rd_req_almostfull(rd_req_almostfull),
    .rd_rsp_valid(rd_rsp_valid), .rd_rsp_mdata(rd_rsp_mdata),
    .rd_rsp_data(rd_rsp_data),
    .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid),
    .rsp_tag(rsp_tag), .rsp_data(rsp_data),
    .drain(drain), .drained(drained),
`ifdef MM_RD_ARB_STATS_EN
    .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1), .stall_cnt(stall_cnt),
`endif
    .rsp_err(rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string nm, input logic [CWD-1:0] act,
                     input logic [CWD-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int             m_cnt[2];
  int             m_phase;      // 0 granting, 1 waiting for returns, 2 drained
  bit             m_last, m_live;
  logic           m_en, m_v0, m_v1, m_err;
  logic [AL-1:0]  m_addr;
  logic [MD-1:0]  m_mdata;
  logic [MD-2:0]  m_tag;
  logic [CWD-1:0] m_data;
  int             m_g0, m_g1, m_stall;

  function automatic bit m_ready(input int k);
    bit open, e0, e1;
    open = (m_phase == 0) && !drain && !rd_req_almostfull;
    e0 = open && rq0_valid && (m_cnt[0] < MO);
    e1 = open && rq1_valid && (m_cnt[1] < MO);
    if (e0 && e1) return (k == 0) ? (m_last == 1'b1) : (m_last == 1'b0);
    return (k == 0) ? e0 : e1;
  endfunction

  initial begin : model
    bit g[2];
    bit d[2];
    int old[2];
    m_live = 0;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_cnt[0] = 0; m_cnt[1] = 0; m_phase = 0; m_last = 1'b1;
        m_en = 0; m_addr = '0; m_mdata = '0; m_v0 = 0; m_v1 = 0;
        m_tag = '0; m_data = '0; m_err = 0; m_live = 1;
        m_g0 = 0; m_g1 = 0; m_stall = 0;
      end else begin
        g[0] = m_ready(0); g[1] = m_ready(1);
        old[0] = m_cnt[0]; old[1] = m_cnt[1];
        m_en = g[0] | g[1];
        if (g[0]) begin m_addr = rq0_addr; m_mdata = {1'b0, rq0_tag}; m_last = 1'b0; end
        if (g[1]) begin m_addr = rq1_addr; m_mdata = {1'b1, rq1_tag}; m_last = 1'b1; end
        if (g[0]) m_g0++;
        if (g[1]) m_g1++;
        if ((rq0_valid || rq1_valid) && !m_en) m_stall++;
        d[0] = rd_rsp_valid && !rd_rsp_mdata[MD-1];
        d[1] = rd_rsp_valid &&  rd_rsp_mdata[MD-1];
        m_v0 = d[0]; m_v1 = d[1];
        if (rd_rsp_valid) begin m_tag = rd_rsp_mdata[MD-2:0]; m_data = rd_rsp_data; end
        for (int k = 0; k < 2; k++) begin
          if (d[k] && old[k] == 0) m_err = 1;
          if (g[k] && !d[k]) m_cnt[k] = old[k] + 1;
          else if (d[k] && !g[k] && old[k] > 0) m_cnt[k] = old[k] - 1;
        end
        case (m_phase)
          0: if (drain) m_phase = 1;
          1: if (!drain) m_phase = 0;
             else if (old[0] == 0 && old[1] == 0) m_phase = 2;
          default: if (!drain) m_phase = 0;
        endcase
      end
    end
  end

  initial begin : compare
    forever begin
      @(negedge clk);
      if (m_live) begin
        chk("rq0_ready", rq0_ready, m_ready(0));
        chk("rq1_ready", rq1_ready, m_ready(1));
        chk("rd_req_en", rd_req_en, m_en);
        chk("rd_req_addr", rd_req_addr, m_addr);
        chk("rd_req_mdata", rd_req_mdata, m_mdata);
        chk("rsp0_valid", rsp0_valid, m_v0);
        chk("rsp1_valid", rsp1_valid, m_v1);
        chk("rsp_tag", rsp_tag, m_tag);
        chk("rsp_data", rsp_data, m_data);
        chk("drained", drained, m_phase == 2);
        chk("rsp_err", rsp_err, m_err);
`ifdef MM_RD_ARB_STATS_EN
        chk("grant_cnt0", grant_cnt0, m_g0);
        chk("grant_cnt1", grant_cnt1, m_g1);
        chk("stall_cnt", stall_cnt, m_stall);
`endif
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic rsp(input bit id, input logic [MD-2:0] tag,
                     input logic [CWD-1:0] dat);
    rd_rsp_valid = 1'b1;
    rd_rsp_mdata = {id, tag};
    rd_rsp_data  = dat;
  endtask

  logic [CWD-1:0] pat;
  int n_gr;

  initial begin : stim
    pat = {8{64'h0123_4567_89AB_CDEF}};
    rst = 1; rq0_valid = 0; rq1_valid = 0;
    rq0_addr = 20'h00100; rq1_addr = 20'h00200;
    rq0_tag = 13'h011; rq1_tag = 13'h022;
    rd_req_almostfull = 0; rd_rsp_valid = 0; rd_rsp_mdata = '0;
    rd_rsp_data = '0; drain = 0;
    tick(2);
    rst = 0;
    chk("reset_en", rd_req_en, 0);
    chk("reset_mdata", rd_req_mdata, 0);
    chk("reset_drained", drained, 0);
    chk("reset_err", rsp_err, 0);

    // Both requesters streaming: grants alternate starting with 0.
    rq0_valid = 1; rq1_valid = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("alt_ready0", rq0_ready, (i % 2) == 0);
      tick();
      chk("alt_mdata_id", rd_req_mdata[MD-1], i % 2);
    end
    chk("alt_last_mdata", rd_req_mdata, {1'b1, 13'h022});
    rq0_valid = 0; rq1_valid = 0;

    // Response routing, back-to-back, draining both counts (2 each).
    rsp(1'b1, 13'h0A5, pat);
    tick();
    chk("route_rsp1_valid", rsp1_valid, 1);
    chk("route_rsp0_valid", rsp0_valid, 0);
    chk("route_tag", rsp_tag, 13'h0A5);
    chk("route_data", rsp_data, pat);
    rsp(1'b0, 13'h001, ~pat); tick();
    rsp(1'b0, 13'h002, pat);  tick();
    rsp(1'b1, 13'h003, pat);  tick();
    rd_rsp_valid = 0; tick();

    // Credit limit: requester 0 alone gets exactly MO grants.
    rq0_valid = 1; n_gr = 0;
    for (int i = 0; i < 6; i++) begin
      #1 if (rq0_ready) n_gr++;
      tick();
    end
    chk("credit_limit_grants", n_gr, MO);
    #1 chk("credit_full_ready0", rq0_ready, 0);
    rsp(1'b0, 13'h003, pat);
    tick();
    rd_rsp_valid = 0;
    #1 chk("credit_freed_ready0", rq0_ready, 1);
    tick();
    #1 chk("credit_refull_ready0", rq0_ready, 0);
    rq0_valid = 0;
    for (int i = 0; i < MO; i++) begin rsp(1'b0, 13'(i), pat); tick(); end
    rd_rsp_valid = 0; tick();

    // Requester 1 at count 3: grant + response together keeps it at 3.
    rq1_valid = 1;
    tick(3);
    rsp(1'b1, 13'h007, pat);
    #1 chk("simul_ready1", rq1_ready, 1);
    tick();
    rd_rsp_valid = 0;
    #1 chk("simul_one_left", rq1_ready, 1);
    tick();
    #1 chk("simul_now_full", rq1_ready, 0);
    rq1_valid = 0;
    for (int i = 0; i < MO; i++) begin rsp(1'b1, 13'(i), pat); tick(); end
    rd_rsp_valid = 0; tick();

    // Almost-full blocks new grants; the request registered earlier issues.
    rq0_valid = 1;
    tick();
    rd_req_almostfull = 1;
    #1 chk("af_ready0", rq0_ready, 0);
    chk("af_prev_issue", rd_req_en, 1);
    tick();
    chk("af_no_issue", rd_req_en, 0);
    rd_req_almostfull = 0; rq0_valid = 0;
    rsp(1'b0, 13'h009, pat); tick();
    rd_rsp_valid = 0; tick();

    // Drain with two reads in flight.
    rq0_valid = 1; rq1_valid = 1;
    tick(2);
    drain = 1;
    #1 chk("drain_ready0", rq0_ready, 0);
    chk("drain_ready1", rq1_ready, 0);
    tick(2);
    chk("drain_wait", drained, 0);
    rsp(1'b0, 13'h00A, pat); tick();
    rsp(1'b1, 13'h00B, pat); tick();
    rd_rsp_valid = 0;
    chk("drain_cnt_zero_cycle", drained, 0);
    tick();
    chk("drained_set", drained, 1);
    tick();
    chk("drained_hold", drained, 1);
    drain = 0; rq0_valid = 0; rq1_valid = 0;
    tick();
    chk("drained_clear", drained, 0);

    // Response with nothing outstanding after a reset.
    rst = 1; tick(); rst = 0;
    chk("err_after_reset", rsp_err, 0);
    rsp(1'b1, 13'h005, pat); tick();
    rd_rsp_valid = 0;
    chk("err_set", rsp_err, 1);
    tick(3);
    chk("err_sticky", rsp_err, 1);
    rst = 1; tick(); rst = 0;
    chk("err_cleared", rsp_err, 0);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
